// File: rtl/ab_policy_monitor.sv
// A->B handshake policy monitor: flags B without A, repeated A and B timeout.
// Optional AB_MONITOR_EDIT_COUNT_EN adds enforcer edit counting (A/B_ctp_in, edit_count).
module ab_policy_monitor #(
  parameter int MAX_TICKS = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             A_ctp_final,
  input  logic             B_ctp_final,
`ifdef AB_MONITOR_EDIT_COUNT_EN
  input  logic             A_ctp_in,
  input  logic             B_ctp_in,
`endif
  input  logic             clear,
  output logic             violation,
  output logic [1:0]       viol_code,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_count,
`ifdef AB_MONITOR_EDIT_COUNT_EN
  output logic [CNT_W-1:0] edit_count,
`endif
  output logic [1:0]       state_out
);

  localparam int TICK_W = $clog2(MAX_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MAX_TICKS - 1);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_B_NO_A   = 2'b01;
  localparam logic [1:0] CODE_A_REPEAT = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_B = 2'b01
  } state_t;

  state_t              state_reg, state_next;
  logic [TICK_W-1:0]   tick_reg, tick_next;
  logic [1:0]          flag_code_next;
  logic                violation_reg;
  logic [1:0]          viol_code_reg;
  logic                viol_sticky_reg;
  logic [CNT_W-1:0]    viol_count_reg, viol_count_next, viol_count_base;

  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    flag_code_next = CODE_NONE;
    case (state_reg)
      IDLE: begin
        if (B_ctp_final) begin
          flag_code_next = CODE_B_NO_A;
        end else if (A_ctp_final) begin
          state_next = WAIT_B;
          tick_next  = '0;
        end
      end
      WAIT_B: begin
        if (B_ctp_final) begin
          state_next = IDLE;
          tick_next  = '0;
        end else if (A_ctp_final) begin
          flag_code_next = CODE_A_REPEAT;
          state_next     = IDLE;
          tick_next      = '0;
        end else if (tick_reg == TICK_LAST) begin
          flag_code_next = CODE_TIMEOUT;
          state_next     = IDLE;
          tick_next      = '0;
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tick_next  = '0;
      end
    endcase
  end

  // A clear in the same cycle as a violation zeroes first, then counts the new event.
  always_comb begin
    viol_count_base = clear ? '0 : viol_count_reg;
    viol_count_next = viol_count_base;
    if (flag_code_next != CODE_NONE && viol_count_base != {CNT_W{1'b1}})
      viol_count_next = viol_count_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      tick_reg        <= '0;
      violation_reg   <= 1'b0;
      viol_code_reg   <= CODE_NONE;
      viol_sticky_reg <= 1'b0;
      viol_count_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      tick_reg        <= tick_next;
      violation_reg   <= (flag_code_next != CODE_NONE);
      if (flag_code_next != CODE_NONE)
        viol_code_reg <= flag_code_next;
      else if (clear)
        viol_code_reg <= CODE_NONE;
      viol_sticky_reg <= (flag_code_next != CODE_NONE) | (viol_sticky_reg & ~clear);
      viol_count_reg  <= viol_count_next;
    end
  end

  assign violation   = violation_reg;
  assign viol_code   = viol_code_reg;
  assign viol_sticky = viol_sticky_reg;
  assign viol_count  = viol_count_reg;
  assign state_out   = state_reg;

`ifdef AB_MONITOR_EDIT_COUNT_EN
  logic [CNT_W-1:0] edit_count_reg, edit_count_next, edit_count_base;
  logic             edit_seen;

  always_comb begin
    edit_seen       = (A_ctp_in != A_ctp_final) || (B_ctp_in != B_ctp_final);
    edit_count_base = clear ? '0 : edit_count_reg;
    edit_count_next = edit_count_base;
    if (edit_seen && edit_count_base != {CNT_W{1'b1}})
      edit_count_next = edit_count_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      edit_count_reg <= '0;
    else
      edit_count_reg <= edit_count_next;
  end

  assign edit_count = edit_count_reg;
`endif

endmodule

// File: tb/tb_ab_policy_monitor.sv
// Directed + randomized bench for ab_policy_monitor against a cycle-index reference model.
module tb_ab_policy_monitor;
  localparam int MAX_TICKS = 5;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic A_ctp_final, B_ctp_final, clear;
  logic violation, viol_sticky;
  logic [1:0] viol_code, state_out;
  logic [CNT_W-1:0] viol_count;
`ifdef AB_MONITOR_EDIT_COUNT_EN
  logic A_ctp_in, B_ctp_in;
  logic [CNT_W-1:0] edit_count;
  int exp_edit;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an outstanding A is remembered by the cycle index it arrived in.
  bit pending;
  int a_cycle, cyc;
  int exp_count;
  bit exp_violation, exp_sticky;
  logic [1:0] exp_code;

  always #5 clk = ~clk;

  ab_policy_monitor #(.MAX_TICKS(MAX_TICKS), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .A_ctp_final(A_ctp_final),
    .B_ctp_final(B_ctp_final),
`ifdef AB_MONITOR_EDIT_COUNT_EN
    .A_ctp_in(A_ctp_in),
    .B_ctp_in(B_ctp_in),
`endif
    .clear(clear),
    .violation(violation),
    .viol_code(viol_code),
    .viol_sticky(viol_sticky),
    .viol_count(viol_count),
`ifdef AB_MONITOR_EDIT_COUNT_EN
    .edit_count(edit_count),
`endif
    .state_out(state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pending = 0; a_cycle = 0; cyc = 0;
    exp_count = 0; exp_violation = 0; exp_sticky = 0; exp_code = 2'b00;
`ifdef AB_MONITOR_EDIT_COUNT_EN
    exp_edit = 0;
`endif
  endtask

  task automatic model_step(input bit a, input bit b, input bit clr, input bit ai, input bit bi);
    logic [1:0] code;
    code = 2'b00;
    if (!pending) begin
      if (b) code = 2'b01;
      else if (a) begin pending = 1; a_cycle = cyc; end
    end else begin
      if (b) pending = 0;
      else if (a) begin code = 2'b10; pending = 0; end
      else if (cyc - a_cycle == MAX_TICKS) begin code = 2'b11; pending = 0; end
    end
    cyc++;
    if (clr) begin exp_count = 0; exp_sticky = 0; exp_code = 2'b00; end
    exp_violation = (code != 2'b00);
    if (code != 2'b00) begin
      exp_code = code;
      exp_sticky = 1;
      if (exp_count < CNT_MAX) exp_count++;
    end
`ifdef AB_MONITOR_EDIT_COUNT_EN
    if (clr) exp_edit = 0;
    if ((ai != a) || (bi != b)) begin
      if (exp_edit < CNT_MAX) exp_edit++;
    end
`endif
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".violation"}, 32'(violation), 32'(exp_violation));
    check({ctx, ".viol_code"}, 32'(viol_code), 32'(exp_code));
    check({ctx, ".viol_sticky"}, 32'(viol_sticky), 32'(exp_sticky));
    check({ctx, ".viol_count"}, 32'(viol_count), 32'(exp_count));
    check({ctx, ".state_out"}, 32'(state_out), pending ? 32'd1 : 32'd0);
`ifdef AB_MONITOR_EDIT_COUNT_EN
    check({ctx, ".edit_count"}, 32'(edit_count), 32'(exp_edit));
`endif
  endtask

  task automatic step(input string ctx, input bit a, input bit b, input bit clr,
                      input bit ai, input bit bi);
    A_ctp_final = a; B_ctp_final = b; clear = clr;
`ifdef AB_MONITOR_EDIT_COUNT_EN
    A_ctp_in = ai; B_ctp_in = bi;
`endif
    @(posedge clk);
    model_step(a, b, clr, ai, bi);
    #1;
    check_all(ctx);
    $display("step %s a=%0b b=%0b clr=%0b -> viol=%0b code=%0d cnt=%0d state=%0d",
             ctx, a, b, clr, violation, viol_code, viol_count, state_out);
  endtask

  task automatic step_s(input string ctx, input bit a, input bit b, input bit clr);
    step(ctx, a, b, clr, a, b);
  endtask

  task automatic check_reset_values(input string ctx);
    check({ctx, ".violation"}, 32'(violation), 32'd0);
    check({ctx, ".viol_code"}, 32'(viol_code), 32'd0);
    check({ctx, ".viol_sticky"}, 32'(viol_sticky), 32'd0);
    check({ctx, ".viol_count"}, 32'(viol_count), 32'd0);
    check({ctx, ".state_out"}, 32'(state_out), 32'd0);
`ifdef AB_MONITOR_EDIT_COUNT_EN
    check({ctx, ".edit_count"}, 32'(edit_count), 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    A_ctp_final = 0; B_ctp_final = 0; clear = 0;
`ifdef AB_MONITOR_EDIT_COUNT_EN
    A_ctp_in = 0; B_ctp_in = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;

    // A then B three cycles later: no violation, back to IDLE.
    step_s("ab_ok0", 1, 0, 0);
    step_s("ab_ok1", 0, 0, 0);
    step_s("ab_ok2", 0, 0, 0);
    step_s("ab_ok3", 0, 1, 0);
    step_s("ab_ok4", 0, 0, 0);

    // A with no B: TIMEOUT after MAX_TICKS idle cycles.
    step_s("to_a", 1, 0, 0);
    for (int i = 0; i < MAX_TICKS; i++) step_s("to_wait", 0, 0, 0);
    check("timeout_code", 32'(viol_code), 32'd3);
    check("timeout_pulse", 32'(violation), 32'd1);
    step_s("to_after", 0, 0, 0);
    check("timeout_pulse_end", 32'(violation), 32'd0);

    // B_NO_A then A_REPEAT.
    step_s("seq_clr", 0, 0, 1);
    step_s("seq_b", 0, 1, 0);
    step_s("seq_a1", 1, 0, 0);
    step_s("seq_a2", 1, 0, 0);
    check("repeat_code", 32'(viol_code), 32'd2);
    check("repeat_count", 32'(viol_count), 32'd2);
    step_s("seq_hold", 0, 0, 0);
    check("code_hold", 32'(viol_code), 32'd2);

    // Counter saturation, then clear together with one more violation.
    for (int i = 0; i < 300; i++) step_s("sat_b", 0, 1, 0);
    check("sat_count", 32'(viol_count), 32'(CNT_MAX));
    step_s("sat_clr_evt", 0, 1, 1);
    check("clr_evt_count", 32'(viol_count), 32'd1);
    check("clr_evt_sticky", 32'(viol_sticky), 32'd1);

    // Clear during WAIT_B must not disturb the pending wait.
    step_s("clr_wait_a", 1, 0, 0);
    step_s("clr_wait_c", 0, 0, 1);
    for (int i = 0; i < MAX_TICKS; i++) step_s("clr_wait", 0, 0, 0);

`ifdef AB_MONITOR_EDIT_COUNT_EN
    step("edit_clr", 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("edit_a", 0, 0, 0, 1, 0);
    check("edit_four", 32'(edit_count), 32'd4);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit a, b, clr, ai, bi;
      a   = ($urandom_range(0, 2) == 0);
      b   = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 31) == 0);
      ai  = ($urandom_range(0, 7) == 0) ? ~a : a;
      bi  = ($urandom_range(0, 7) == 0) ? ~b : b;
      step("rand", a, b, clr, ai, bi);
    end

    // Reset mid-WAIT_B: wait is abandoned, no later TIMEOUT.
    step_s("rst_a", 1, 0, 0);
    step_s("rst_w", 0, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < MAX_TICKS + 3; i++) step_s("post_rst", 0, 0, 0);
    check("post_rst_noviol", 32'(viol_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ab_policy_monitor.md
AB_POLICY_MONITOR -- requirements
Module: ab_policy_monitor

Interface
REQ-001 Parameter MAX_TICKS, default 5: the number of cycles after an A within which a B SHALL arrive; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of all event counters.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 A_ctp_final  input  1  enforced A signal observed after the enforcer.
REQ-006 B_ctp_final  input  1  enforced B signal observed after the enforcer.
REQ-007 A_ctp_in  input  1  pre-enforcement A signal; present only with AB_MONITOR_EDIT_COUNT_EN.
REQ-008 B_ctp_in  input  1  pre-enforcement B signal; present only with AB_MONITOR_EDIT_COUNT_EN.
REQ-009 clear  input  1  synchronous clear of viol_sticky and of all counters.
REQ-010 violation  output  1  single-cycle pulse marking one detected policy violation.
REQ-011 viol_code  output  2  cause of the latest violation: 01 B_NO_A, 10 A_REPEAT, 11 TIMEOUT, 00 none.
REQ-012 viol_sticky  output  1  set by any violation; held until clear or reset.
REQ-013 viol_count  output  CNT_W  saturating count of violations.
REQ-014 edit_count  output  CNT_W  saturating count of cycles in which the enforcer changed a signal; present only with AB_MONITOR_EDIT_COUNT_EN.
REQ-015 state_out  output  2  current monitor state: 00 IDLE, 01 WAIT_B.

Function
REQ-016 All outputs SHALL be registered; a violation sampled in cycle N SHALL be visible on violation and viol_code in cycle N+1.
REQ-017 In IDLE with B_final=1 (with or without A): the block SHALL flag B_NO_A and remain in IDLE.
REQ-018 In IDLE with A_final=1 and B_final=0: the block SHALL enter WAIT_B with tick=0 and flag nothing.
REQ-019 In IDLE with both signals at 0: the block SHALL remain in IDLE with no flag.
REQ-020 In WAIT_B with B_final=1 (A either value): the block SHALL return to IDLE with no flag.
REQ-021 In WAIT_B with A_final=1 and B_final=0: the block SHALL flag A_REPEAT and return to IDLE.
REQ-022 In WAIT_B with both signals at 0 and tick=MAX_TICKS-1: the block SHALL flag TIMEOUT and return to IDLE.
REQ-023 In WAIT_B with both signals at 0 and tick<MAX_TICKS-1: tick SHALL increment and the state SHALL not change.
REQ-024 viol_code SHALL hold its last nonzero value until clear or reset.
REQ-025 The tick counter SHALL be ceil(log2(MAX_TICKS+1)) bits wide and SHALL never wrap.
REQ-026 viol_count and edit_count SHALL saturate at all-ones and never wrap.
REQ-027 edit_count SHALL increment by at most 1 per cycle, in cycles where (A_ctp_in!=A_ctp_final) or (B_ctp_in!=B_ctp_final).
REQ-028 clear SHALL zero viol_sticky, viol_code and the counters without affecting the FSM state or tick.
REQ-029 If clear and an event arrive in the same cycle, the event SHALL be counted after the clear (resulting count 1, sticky 1).

Reset
REQ-030 While reset_n=0, state_out=IDLE, tick=0, violation=0, viol_code=00, viol_sticky=0, viol_count=0 and edit_count=0.
REQ-031 Reset asserted mid-WAIT_B SHALL abandon the pending wait; no TIMEOUT SHALL be reported after release.
REQ-032 Deassertion of reset_n SHALL take effect on the next rising edge of clk.

Configuration
REQ-033 With AB_MONITOR_EDIT_COUNT_EN defined, A_ctp_in, B_ctp_in, edit_count and the edit logic SHALL be present.
REQ-034 Without AB_MONITOR_EDIT_COUNT_EN, those ports and that logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-035 A=1 at cycle 0, B=1 at cycle 3 -> no violation; state_out=00 at cycle 4.
REQ-036 A=1 at cycle 0, no B afterwards (MAX_TICKS=5) -> violation pulse with viol_code=11 at cycle 6; viol_count=1.
REQ-037 B=1 in IDLE, then A=1 twice in a row -> B_NO_A flagged, then A_REPEAT flagged on the second A; viol_count=2; viol_sticky=1.
REQ-038 300 consecutive B-only cycles with CNT_W=8 -> viol_count holds 255; clear asserted together with one more violation -> viol_count=1.
REQ-039 With macro: A_ctp_in=1 and A_ctp_final=0 for 4 cycles -> edit_count=4; reset_n pulsed low mid-WAIT_B -> all outputs 0 and no later TIMEOUT.
